multicycle_control: RTL

// Multicycle sequencer for the MIPS datapath: one instruction per FETCH/DECODE/EXEC/[MEM]/[WB] pass,

---
 rtl/multicycle_control.sv | 111 +++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle MIPS datapath,
// with a memory req/ready handshake, bus timeout and sticky illegal/bus_error halt flags.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic        bus_error,
  output logic [2:0]  state
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_NOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;
  localparam logic [1:0] SRC_REG = 2'd0, SRC_SEXT = 2'd1, SRC_ZEXT = 2'd2, SRC_SHAMT = 2'd3;
  localparam logic [7:0] TO = TIMEOUT[7:0];

  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d, bus_error_q, bus_error_d;
  logic [5:0] op, funct;
  logic       is_r, r_ok, is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_br, legal;
  logic       timeout, done, unused;

  assign op      = instruction[31:26];
  assign funct   = instruction[5:0];
  assign unused  = ^instruction[25:6];
  assign is_r    = op == 6'h00;
  assign r_ok    = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h25 ||
                            funct == 6'h27 || funct == 6'h2A || funct == 6'h00 || funct == 6'h02);
  assign is_addi = op == 6'h08;
  assign is_andi = op == 6'h0C;
  assign is_ori  = op == 6'h0D;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign is_j    = op == 6'h02;
  assign is_br   = is_beq || is_bne;
  assign legal   = r_ok || is_addi || is_andi || is_ori || is_lw || is_sw || is_br || is_j;

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign mem_req      = rst_n && (state_q == FETCH || state_q == MEM);
  assign mem_we       = rst_n && state_q == MEM && is_sw;
  assign mem_addr_src = state_q == MEM;
  assign ir_write     = rst_n && state_q == FETCH && mem_ready;
  assign pc_write     = rst_n && ((state_q == FETCH && mem_ready) || (state_q == DECODE && is_j) ||
                                  (state_q == EXEC && is_br && (zero ^ is_bne)));
  assign pc_src       = (state_q == DECODE && is_j) ? 2'd2 : (state_q == EXEC && is_br) ? 2'd1 : 2'd0;
  assign reg_write    = rst_n && state_q == WB;
  assign reg_dst      = is_r;
  assign mem_to_reg   = is_lw;
  assign done         = mem_req && mem_ready;
  assign timeout      = mem_req && !mem_ready && cnt_q >= TO;
  assign illegal      = illegal_q;
  assign bus_error    = bus_error_q;
  assign state        = state_q;

  always_comb begin
    alu_op  = is_r ? (funct == 6'h22 ? OP_SUB : funct == 6'h24 ? OP_AND : funct == 6'h25 ? OP_OR :
                      funct == 6'h27 ? OP_NOR : funct == 6'h2A ? OP_SLT : funct == 6'h00 ? OP_SLL :
                      funct == 6'h02 ? OP_SRL : OP_ADD)
                   : (is_andi ? OP_AND : is_ori ? OP_OR : is_br ? OP_SUB : OP_ADD);
    alu_src = is_r ? ((funct == 6'h00 || funct == 6'h02) ? SRC_SHAMT : SRC_REG)
                   : ((is_andi || is_ori) ? SRC_ZEXT : is_br ? SRC_REG : SRC_SEXT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = done ? DECODE : timeout ? HALT : FETCH;
      DECODE:  state_d = !legal ? HALT : is_j ? FETCH : EXEC;
      EXEC:    state_d = is_br ? FETCH : (is_lw || is_sw) ? MEM : WB;
      MEM:     state_d = done ? (is_sw ? FETCH : WB) : timeout ? HALT : MEM;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
    cnt_d       = (mem_req && !mem_ready) ? cnt_q + 8'd1 : 8'd0;
    illegal_d   = illegal_q || (state_q == DECODE && !legal);
    bus_error_d = bus_error_q || timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      cnt_q       <= 8'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end
endmodule
